// File: rtl/nor_unit_arbiter_if.sv
// ----------------------------------------------------------------------------
// nor_unit_arbiter_if
//   Handshake bundle between the lab-board requesters, the result consumer and
//   the shared NOR unit arbiter.
//
//   req_valid  NREQ        requester i has an operation pending
//   req_a      NREQ*WIDTH  operand a, requester i in [i*WIDTH +: WIDTH]
//   req_b      NREQ*WIDTH  operand b, same packing as req_a
//   req_ready  NREQ        one-hot grant from the arbiter
//   rsp_valid  1           result held on rsp_data/rsp_id
//   rsp_ready  1           consumer accepts the result
//   rsp_data   WIDTH       ~(a | b) of the granted operands
//   rsp_id     IDW         index of the requester owning rsp_data
//
//   master: requester/consumer side; slave: arbiter side.
// ----------------------------------------------------------------------------
interface nor_unit_arbiter_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/nor_unit_arbiter.sv
// ----------------------------------------------------------------------------
// nor_unit_arbiter
//   Shares one WIDTH-bit bitwise NOR unit (c = ~(a | b)) between NREQ
//   requesters with round-robin arbitration. One operation in flight at a
//   time: IDLE grants and latches operands, EXEC computes, RESP holds the
//   result until the consumer accepts it. Counts accepted results.
//
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous reset, active-low
//   bus       slave modport of nor_unit_arbiter_if (requests and result)
//   busy      out  FSM not in IDLE
//   op_count  out  results accepted since reset, wraps modulo 2^CNTW
// ----------------------------------------------------------------------------
module nor_unit_arbiter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  nor_unit_arbiter_if.slave   bus,
  output logic                busy,
  output logic [CNTW-1:0]     op_count
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDW-1:0]   id_r;

  logic [WIDTH-1:0] rsp_data_r;
  logic [IDW-1:0]   rsp_id_r;
  logic             rsp_valid_r;
  logic [CNTW-1:0]  op_count_r;

  logic             found;
  logic [IDW-1:0]   winner;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             rsp_accept;

  // Round-robin scan starting at rr_ptr; the first pending requester wins.
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(rr_ptr) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is suppressed during reset so no transfer can be seen while rst_n=0.
  assign grant      = rst_n && (state == IDLE) && found;
  assign rsp_accept = (state == RESP) && rsp_valid_r && bus.rsp_ready;

  always_comb begin
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready = NREQ'(1) << winner;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      a_r         <= '0;
      b_r         <= '0;
      id_r        <= '0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
      op_count_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            a_r    <= a_sel;
            b_r    <= b_sel;
            id_r   <= winner;
            rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        EXEC: begin
          rsp_data_r  <= ~(a_r | b_r);
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (rsp_accept) begin
            rsp_valid_r <= 1'b0;
            op_count_r  <= op_count_r + 1'b1;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign busy          = (state != IDLE);
  assign op_count      = op_count_r;

endmodule

// File: tb/tb_nor_unit_arbiter.sv
module tb_nor_unit_arbiter;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] op_count;

  int n_vec;
  int n_err;

  nor_unit_arbiter_if #(.WIDTH(3), .NREQ(4)) bus ();

  nor_unit_arbiter #(.WIDTH(3), .NREQ(4), .CNTW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] e_rr;
    logic       e_val;
    logic [2:0] e_data;
    logic [1:0] e_id;
    logic       e_busy;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete operation with rsp_ready held high: wait for a grant,
  // check it, wait for the result, check it, let the accept edge pass.
  task automatic do_op(input int exp_id, input logic [2:0] exp_data);
    int n;
    logic [3:0] e;
    e = '0;
    e[exp_id] = 1'b1;
    n = 0;
    while (bus.req_ready == 4'b0000 && n < 10) begin
      step();
      n++;
    end
    check("grant", 32'(bus.req_ready), 32'(e));
    step();
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("op_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("op_rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check("op_rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    step();
  endtask

  logic [2:0] exp_rr [4];
  logic [2:0] bp_data;
  logic [1:0] bp_id;
  int         order [5];

  initial begin
    n_vec = 0;
    n_err = 0;

    //            rst   rv     rdy   rr     val   data    id     busy  cnt
    tbl[0]  = '{1'b0, 4'hF,  1'b0, 4'h0,  1'b0, 3'b000, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'hF,  1'b0, 4'h0,  1'b0, 3'b000, 2'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 4'h4,  1'b1, 4'h4,  1'b0, 3'b000, 2'd0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 4'h0,  1'b1, 4'h0,  1'b0, 3'b000, 2'd0, 1'b1, 8'd0};
    tbl[4]  = '{1'b1, 4'h0,  1'b1, 4'h0,  1'b1, 3'b010, 2'd2, 1'b1, 8'd0};
    tbl[5]  = '{1'b1, 4'h0,  1'b1, 4'h0,  1'b0, 3'b010, 2'd2, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 4'h9,  1'b0, 4'h8,  1'b0, 3'b010, 2'd2, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 4'h9,  1'b0, 4'h0,  1'b0, 3'b010, 2'd2, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 4'h9,  1'b0, 4'h0,  1'b1, 3'b000, 2'd3, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 4'h9,  1'b1, 4'h0,  1'b1, 3'b000, 2'd3, 1'b1, 8'd1};
    tbl[10] = '{1'b1, 4'h9,  1'b1, 4'h1,  1'b0, 3'b000, 2'd3, 1'b0, 8'd2};
    tbl[11] = '{1'b1, 4'h0,  1'b1, 4'h0,  1'b0, 3'b000, 2'd3, 1'b1, 8'd2};
    tbl[12] = '{1'b1, 4'h0,  1'b1, 4'h0,  1'b1, 3'b101, 2'd0, 1'b1, 8'd2};
    tbl[13] = '{1'b1, 4'h0,  1'b1, 4'h0,  1'b0, 3'b101, 2'd0, 1'b0, 8'd3};

    // Operands for the table: req3 111/000, req2 001/100, req1 000/000, req0 010/000.
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a     = {3'b111, 3'b001, 3'b000, 3'b010};
    bus.req_b     = {3'b000, 3'b100, 3'b000, 3'b000};
    bus.rsp_ready = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      rst_n         = tbl[i].rst_n;
      bus.req_valid = tbl[i].rv;
      bus.rsp_ready = tbl[i].rdy;
      #1;
      check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rr));
      check($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_val));
      check($sformatf("v%0d_rsp_data", i), 32'(bus.rsp_data), 32'(tbl[i].e_data));
      check($sformatf("v%0d_rsp_id", i), 32'(bus.rsp_id), 32'(tbl[i].e_id));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("v%0d_op_count", i), 32'(op_count), 32'(tbl[i].e_cnt));
      step();
    end

    // Round-robin from a fresh reset: all four pending, grant order 0,1,2,3,0.
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    bus.req_a     = {3'b100, 3'b010, 3'b001, 3'b000};
    bus.req_b     = {3'b000, 3'b001, 3'b100, 3'b011};
    exp_rr[0] = 3'b100;
    exp_rr[1] = 3'b010;
    exp_rr[2] = 3'b100;
    exp_rr[3] = 3'b011;
    step();
    step();
    rst_n = 1'b1;
    #1;
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      do_op(order[k], exp_rr[order[k]]);
    end
    check("rr_op_count", 32'(op_count), 32'd5);

    // Backpressure: requester 1 only, consumer stalls for 5 cycles.
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'h2);
    step();
    step();
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bp_data = bus.rsp_data;
    bp_id   = bus.rsp_id;
    check("bp_data", 32'(bp_data), 32'(3'b010));
    check("bp_id", 32'(bp_id), 32'd1);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_data", 32'(bus.rsp_data), 32'(3'b010));
      check("bp_hold_id", 32'(bus.rsp_id), 32'd1);
      check("bp_hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_count", 32'(op_count), 32'd6);

    // Reset during EXEC: rr_ptr is 2 here, reset must bring it back to 0.
    bus.req_valid = 4'b0100;
    #1;
    check("mid_grant", 32'(bus.req_ready), 32'h4);
    step();
    check("mid_busy_exec", 32'(busy), 32'd1);
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    check("mid_req_ready_in_reset", 32'(bus.req_ready), 32'h0);
    step();
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_count", 32'(op_count), 32'd0);
    rst_n         = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    check("mid_first_grant", 32'(bus.req_ready), 32'h1);

    // Counter wrap: 256 ops from requester 0, operands alternating 000 and 111.
    bus.req_valid = 4'b0001;
    bus.req_b     = '0;
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 0) begin
        bus.req_a = {9'b0, 3'b000};
        bus.req_b = {9'b0, 3'b000};
        do_op(0, 3'b111);
      end else begin
        bus.req_a = {9'b0, 3'b111};
        bus.req_b = {9'b0, 3'b111};
        do_op(0, 3'b000);
      end
      if (k == 254) check("wrap_count_255", 32'(op_count), 32'd255);
    end
    check("wrap_count_0", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
